reveal_ctrl: RTL
================

Name: reveal_ctrl

Overview:
Gameplay controller that sequences the board's single registered read port (x/y address in, 5-bit cell value out) to service player commands.
- Tracks per-cell revealed and flagged state.
- Runs an iterative flood-fill reveal for zero-valued cells using an internal coordinate FIFO.
- Counts revealed cells and flags, and decides win or loss.
- Sits between the input/cursor logic (command source) and the board generator; the display reads its state through a separate port.

Parameters:
X_SIZE, 16, board width in cells
Y_SIZE, 16, board height in cells
X_BITS, 4, x coordinate width
Y_BITS, 4, y coordinate width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
board_ready  in  1  board generation complete (board is_init==0)
num_mines  in  X_BITS+Y_BITS  mine count from board, valid while board_ready
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
cmd_op  in  1  0=reveal, 1=toggle flag
cmd_x  in  X_BITS  command x
cmd_y  in  Y_BITS  command y
brd_x  out  X_BITS  board read address x (registered)
brd_y  out  Y_BITS  board read address y (registered)
brd_val  in  5  board cell value: bit4=1 mine (5'h1F), else 0..8
disp_x  in  X_BITS  display query x
disp_y  in  Y_BITS  display query y
disp_revealed  out  1  revealed bit of (disp_x,disp_y), 1-cycle registered
disp_flagged  out  1  flagged bit of (disp_x,disp_y), 1-cycle registered
game_state  out  2  00=WAIT, 01=PLAY, 10=WON, 11=LOST
busy  out  1  high in RD/EVAL/NBR/POP/FIN
revealed_count  out  X_BITS+Y_BITS+1  number of revealed cells
flag_count  out  X_BITS+Y_BITS+1  number of flagged cells
lose_x, lose_y  out  X_BITS/Y_BITS  coordinate of detonated mine, valid in LOST

Behaviour:
- Reset (async) puts all outputs, arrays, counters, FIFO pointers, brd_x/brd_y, lose_x/lose_y and disp_* to 0; state WAIT; cmd_ready=0.
- Board read timing: brd_x/brd_y update on the edge entering RD. The board samples them at the end of RD. brd_val is used only in EVAL.
- WAIT: all arrays, counters and the FIFO are held clear. On board_ready=1, go to PLAY.
- Any state other than WAIT: board_ready=0 forces WAIT next cycle, aborts any flood fill and clears everything. This has priority over all other transitions.
- PLAY: cmd_ready=1; no other state asserts cmd_ready.
- Flag toggle accepted in PLAY:
  - Cell not revealed: invert its flag bit and adjust flag_count by +1 or -1.
  - Cell revealed: no-op.
  - Either way, stay in PLAY; a 1-cycle operation.
- Reveal accepted in PLAY:
  - Cell revealed or flagged: no-op, stay in PLAY.
  - Otherwise latch the coordinate and go to RD.
- RD: wait one cycle, then go to EVAL.
- EVAL for a direct command:
  - brd_val[4]=1: set the revealed bit, latch lose_x/lose_y, go to LOST.
  - Otherwise set the revealed bit and increment revealed_count.
- EVAL for a cell popped from the FIFO: already counted at enqueue, no count change.
- EVAL exit, both cases:
  - brd_val==0: go to NBR with idx=0.
  - Otherwise: go to POP if the FIFO is non-empty, else FIN.
- NBR: one neighbour per cycle, idx 0..7 in order UL,U,UR,L,R,DL,D,DR.
  - A neighbour qualifies if it is in bounds (no wrap at x=0, x=X_SIZE-1, y=0, y=Y_SIZE-1) and is neither revealed nor flagged.
  - A qualifying neighbour is pushed to the FIFO, its revealed bit is set and revealed_count is incremented in the same cycle.
  - Neighbours of a zero cell are never mines.
  - After idx 7: go to POP if the FIFO is non-empty, else FIN.
- POP: dequeue the head, load brd_x/brd_y, go to RD.
- FIFO:
  - Depth X_SIZE*Y_SIZE, so overflow is impossible because each cell is enqueued at most once.
  - Push and pop never occur in the same cycle.
  - Pointers wrap modulo the depth.
- FIN:
  - revealed_count == X_SIZE*Y_SIZE - num_mines: go to WON.
  - Otherwise go to PLAY.
- WON/LOST: terminal. Commands are not accepted; exit only via reset or a board_ready drop.
- Flagged cells are never auto-revealed; a flood fill stops at them.
- Display port is independent of the board port: each cycle, disp_revealed/disp_flagged are registered from the arrays at disp_x/disp_y.
- Numbered-cell reveal latency: accept edge to cmd_ready=1 again is 4 cycles (RD, EVAL, FIN, PLAY).

Test Plan:
- Reset with board_ready=0 then raise it -> game_state 00, then 01 one cycle after board_ready=1; all counters 0, cmd_ready=1.
- Model board with mine only at (0,0), (1,0)=1, num_mines=1; reveal (1,0) -> revealed_count=1, brd_x/brd_y=(1,0) in RD, cmd_ready high again 4 cycles after accept, state PLAY.
- Same board; reveal (15,15) (value 0) -> flood fill reveals all 255 non-mine cells, revealed_count=255, game_state=10, (0,0) not revealed.
- Flag (5,5) on all-zero board with num_mines=0, then reveal (0,0) -> flag_count=1, revealed_count=255, (5,5) unrevealed, state stays 01; toggle (5,5) again -> flag_count=0.
- Reveal mine at (0,0) -> game_state=11, lose_x=0, lose_y=0, cmd_ready stays 0 under further cmd_valid.
- Drop board_ready mid flood fill (busy=1) -> next cycle game_state=00, revealed_count=0, FIFO empty, disp_revealed=0 for previously revealed cells.

Source files
------------

// File: rtl/reveal_ctrl.sv
// Gameplay controller: sequences the board read port, tracks revealed/flagged
// cells, runs an iterative flood-fill reveal through a coordinate FIFO and decides win/loss.
module reveal_ctrl #(
    parameter int X_SIZE = 16,
    parameter int Y_SIZE = 16,
    parameter int X_BITS = 4,
    parameter int Y_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     board_ready,
    input  logic [X_BITS+Y_BITS-1:0] num_mines,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [X_BITS-1:0]        cmd_x,
    input  logic [Y_BITS-1:0]        cmd_y,
    output logic [X_BITS-1:0]        brd_x,
    output logic [Y_BITS-1:0]        brd_y,
    input  logic [4:0]               brd_val,
    input  logic [X_BITS-1:0]        disp_x,
    input  logic [Y_BITS-1:0]        disp_y,
    output logic                     disp_revealed,
    output logic                     disp_flagged,
    output logic [1:0]               game_state,
    output logic                     busy,
    output logic [X_BITS+Y_BITS:0]   revealed_count,
    output logic [X_BITS+Y_BITS:0]   flag_count,
    output logic [X_BITS-1:0]        lose_x,
    output logic [Y_BITS-1:0]        lose_y
);

    localparam int NCELLS = X_SIZE * Y_SIZE;
    localparam int PTR_W  = X_BITS + Y_BITS;
    localparam int CNT_W  = X_BITS + Y_BITS + 1;

    localparam logic [3:0] ST_WAIT = 4'd0;
    localparam logic [3:0] ST_PLAY = 4'd1;
    localparam logic [3:0] ST_RD   = 4'd2;
    localparam logic [3:0] ST_EVAL = 4'd3;
    localparam logic [3:0] ST_NBR  = 4'd4;
    localparam logic [3:0] ST_POP  = 4'd5;
    localparam logic [3:0] ST_FIN  = 4'd6;
    localparam logic [3:0] ST_WON  = 4'd7;
    localparam logic [3:0] ST_LOST = 4'd8;

    function automatic logic [PTR_W-1:0] cell_idx(input logic [X_BITS-1:0] x,
                                                  input logic [Y_BITS-1:0] y);
        return PTR_W'(y) * PTR_W'(X_SIZE) + PTR_W'(x);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NCELLS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [3:0]         state_q, state_d;
    logic [NCELLS-1:0]  revealed_q, revealed_d;
    logic [NCELLS-1:0]  flagged_q, flagged_d;
    logic [X_BITS-1:0]  cur_x_q, cur_x_d;
    logic [Y_BITS-1:0]  cur_y_q, cur_y_d;
    logic               from_fifo_q, from_fifo_d;
    logic [2:0]         idx_q, idx_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]   revealed_count_q, revealed_count_d;
    logic [CNT_W-1:0]   flag_count_q, flag_count_d;
    logic [X_BITS-1:0]  brd_x_q, brd_x_d;
    logic [Y_BITS-1:0]  brd_y_q, brd_y_d;
    logic [X_BITS-1:0]  lose_x_q, lose_x_d;
    logic [Y_BITS-1:0]  lose_y_q, lose_y_d;
    logic               disp_revealed_q, disp_revealed_d;
    logic               disp_flagged_q, disp_flagged_d;

    logic [PTR_W-1:0]   fifo_mem [NCELLS];
    logic               fifo_push;

    logic               x_dec, x_inc, y_dec, y_inc;
    logic               nbr_in, nbr_ok;
    logic [X_BITS-1:0]  nbr_x;
    logic [Y_BITS-1:0]  nbr_y;
    logic [PTR_W-1:0]   nbr_idx, cur_idx, cmd_idx;

    // Neighbour order UL,U,UR,L,R,DL,D,DR; edges never wrap.
    always_comb begin
        x_dec = (idx_q == 3'd0) || (idx_q == 3'd3) || (idx_q == 3'd5);
        x_inc = (idx_q == 3'd2) || (idx_q == 3'd4) || (idx_q == 3'd7);
        y_dec = (idx_q <= 3'd2);
        y_inc = (idx_q >= 3'd5);
        nbr_in = !(x_dec && cur_x_q == '0) &&
                 !(x_inc && cur_x_q == X_BITS'(X_SIZE - 1)) &&
                 !(y_dec && cur_y_q == '0) &&
                 !(y_inc && cur_y_q == Y_BITS'(Y_SIZE - 1));
        nbr_x = x_dec ? cur_x_q - X_BITS'(1) : (x_inc ? cur_x_q + X_BITS'(1) : cur_x_q);
        nbr_y = y_dec ? cur_y_q - Y_BITS'(1) : (y_inc ? cur_y_q + Y_BITS'(1) : cur_y_q);
        nbr_idx = cell_idx(nbr_x, nbr_y);
        nbr_ok = nbr_in && !revealed_q[nbr_idx] && !flagged_q[nbr_idx];
        cur_idx = cell_idx(cur_x_q, cur_y_q);
        cmd_idx = cell_idx(cmd_x, cmd_y);
    end

    always_comb begin
        state_d          = state_q;
        revealed_d       = revealed_q;
        flagged_d        = flagged_q;
        cur_x_d          = cur_x_q;
        cur_y_d          = cur_y_q;
        from_fifo_d      = from_fifo_q;
        idx_d            = idx_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        fifo_cnt_d       = fifo_cnt_q;
        revealed_count_d = revealed_count_q;
        flag_count_d     = flag_count_q;
        brd_x_d          = brd_x_q;
        brd_y_d          = brd_y_q;
        lose_x_d         = lose_x_q;
        lose_y_d         = lose_y_q;
        fifo_push        = 1'b0;
        disp_revealed_d  = revealed_q[cell_idx(disp_x, disp_y)];
        disp_flagged_d   = flagged_q[cell_idx(disp_x, disp_y)];

        case (state_q)
            ST_WAIT: begin
                if (board_ready) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (cmd_valid && !revealed_q[cmd_idx]) begin
                    if (cmd_op) begin
                        flagged_d[cmd_idx] = ~flagged_q[cmd_idx];
                        flag_count_d = flagged_q[cmd_idx] ? flag_count_q - CNT_W'(1)
                                                          : flag_count_q + CNT_W'(1);
                    end else if (!flagged_q[cmd_idx]) begin
                        cur_x_d     = cmd_x;
                        cur_y_d     = cmd_y;
                        brd_x_d     = cmd_x;
                        brd_y_d     = cmd_y;
                        from_fifo_d = 1'b0;
                        state_d     = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_EVAL;
            ST_EVAL: begin
                // Popped cells were revealed and counted when they were enqueued.
                if (!from_fifo_q) revealed_d[cur_idx] = 1'b1;
                if (!from_fifo_q && brd_val[4]) begin
                    lose_x_d = cur_x_q;
                    lose_y_d = cur_y_q;
                    state_d  = ST_LOST;
                end else begin
                    if (!from_fifo_q) revealed_count_d = revealed_count_q + CNT_W'(1);
                    if (brd_val == 5'd0) begin
                        idx_d   = 3'd0;
                        state_d = ST_NBR;
                    end else begin
                        state_d = (fifo_cnt_q != '0) ? ST_POP : ST_FIN;
                    end
                end
            end
            ST_NBR: begin
                if (nbr_ok) begin
                    fifo_push           = 1'b1;
                    revealed_d[nbr_idx] = 1'b1;
                    revealed_count_d    = revealed_count_q + CNT_W'(1);
                    wr_ptr_d            = ptr_next(wr_ptr_q);
                    fifo_cnt_d          = fifo_cnt_q + CNT_W'(1);
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = (fifo_cnt_d != '0) ? ST_POP : ST_FIN;
            end
            ST_POP: begin
                {cur_y_d, cur_x_d} = fifo_mem[rd_ptr_q];
                {brd_y_d, brd_x_d} = fifo_mem[rd_ptr_q];
                from_fifo_d        = 1'b1;
                rd_ptr_d           = ptr_next(rd_ptr_q);
                fifo_cnt_d         = fifo_cnt_q - CNT_W'(1);
                state_d            = ST_RD;
            end
            ST_FIN: begin
                state_d = (revealed_count_q == CNT_W'(NCELLS) - CNT_W'(num_mines)) ? ST_WON
                                                                                   : ST_PLAY;
            end
            ST_WON, ST_LOST: state_d = state_q;
            default: state_d = ST_WAIT;
        endcase

        // Losing the board wipes the game from any state, overriding everything above.
        if (state_q == ST_WAIT || !board_ready) begin
            if (!board_ready) state_d = ST_WAIT;
            revealed_d       = '0;
            flagged_d        = '0;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            fifo_cnt_d       = '0;
            revealed_count_d = '0;
            flag_count_d     = '0;
            idx_d            = '0;
            from_fifo_d      = 1'b0;
            lose_x_d         = '0;
            lose_y_d         = '0;
            fifo_push        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_WAIT;
            revealed_q       <= '0;
            flagged_q        <= '0;
            cur_x_q          <= '0;
            cur_y_q          <= '0;
            from_fifo_q      <= 1'b0;
            idx_q            <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            fifo_cnt_q       <= '0;
            revealed_count_q <= '0;
            flag_count_q     <= '0;
            brd_x_q          <= '0;
            brd_y_q          <= '0;
            lose_x_q         <= '0;
            lose_y_q         <= '0;
            disp_revealed_q  <= 1'b0;
            disp_flagged_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            revealed_q       <= revealed_d;
            flagged_q        <= flagged_d;
            cur_x_q          <= cur_x_d;
            cur_y_q          <= cur_y_d;
            from_fifo_q      <= from_fifo_d;
            idx_q            <= idx_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            fifo_cnt_q       <= fifo_cnt_d;
            revealed_count_q <= revealed_count_d;
            flag_count_q     <= flag_count_d;
            brd_x_q          <= brd_x_d;
            brd_y_q          <= brd_y_d;
            lose_x_q         <= lose_x_d;
            lose_y_q         <= lose_y_d;
            disp_revealed_q  <= disp_revealed_d;
            disp_flagged_q   <= disp_flagged_d;
        end
    end

    // FIFO storage holds packed {y,x}; pointers and count carry validity, so no reset.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q] <= {nbr_y, nbr_x};
    end

    assign cmd_ready      = (state_q == ST_PLAY);
    assign busy           = (state_q == ST_RD) || (state_q == ST_EVAL) || (state_q == ST_NBR) ||
                            (state_q == ST_POP) || (state_q == ST_FIN);
    assign game_state     = (state_q == ST_WAIT) ? 2'b00 :
                            (state_q == ST_WON)  ? 2'b10 :
                            (state_q == ST_LOST) ? 2'b11 : 2'b01;
    assign brd_x          = brd_x_q;
    assign brd_y          = brd_y_q;
    assign revealed_count = revealed_count_q;
    assign flag_count     = flag_count_q;
    assign lose_x         = lose_x_q;
    assign lose_y         = lose_y_q;
    assign disp_revealed  = disp_revealed_q;
    assign disp_flagged   = disp_flagged_q;

endmodule
